// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch front end.
//   INST_W / ADDR_W    : instruction and address widths
//   RESET_PC_DEFAULT   : default boot PC
//   NOP_INST           : word presented on id_inst when nothing is buffered
//   fetch_bundle_t     : {inst, pc} pair handed from fetch to decode
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch bundles. Used both as the instruction buffer and as
// the queue that carries each outstanding request's PC.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : drop all entries (dominates push/pop)
//   push       : write push_data
//   pop        : discard head (ignored when empty)
//   head       : oldest entry, valid when !empty
//   count      : number of stored entries
//   full/empty : status flags
// DEPTH need not be a power of two; pointers wrap explicitly.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  fetch_bundle_t    push_data,
    input  logic             pop,
    output fetch_bundle_t    head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_bundle_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    push_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && full && !do_pop));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: holds the PC, issues in-order word fetches,
// buffers returned words and hands {inst, pc} to decode over valid/ready.
//   clk, rst                     : clock, asynchronous active-high reset
//   imem_req_valid/ready, addr   : fetch request channel
//   imem_rsp_valid, imem_rsp_data: in-order response channel
//   redirect_valid, redirect_pc  : single-cycle flush and new PC
//   id_valid/ready, id_inst/pc   : decode handshake
// Optional macro FETCH_BYPASS_EN: a response arriving while the buffer is
// empty is forwarded combinationally to decode in the same cycle.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned       FIFO_DEPTH      = 2,
    parameter int unsigned       MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [OUT_W-1:0]  drop_q, drop_d;

    fetch_bundle_t     fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

    fetch_bundle_t     pcq_head;
    logic [OUT_W-1:0]  pcq_count;
    logic              pcq_full, pcq_empty;

    logic [SUM_W-1:0]  in_flight;
    logic              accept;
    logic              rsp_keep;
    logic              bypass;

    // Words already buffered plus words still owed by memory that will be kept.
    assign in_flight = SUM_W'(fifo_count) + SUM_W'(outstanding_q) - SUM_W'(drop_q);

    assign imem_req_valid = !rst && !redirect_valid &&
                            (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                            (in_flight < SUM_W'(FIFO_DEPTH));
    assign imem_addr      = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is kept only if it belongs to the current fetch stream.
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = !rst && fifo_empty && rsp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid  = !rst && !redirect_valid && (!fifo_empty || bypass);
    assign fifo_pop  = id_valid && id_ready && !fifo_empty;
    assign fifo_push = rsp_keep && !(bypass && id_ready);

    always_comb begin
        id_inst = NOP_INST;
        id_pc   = pc_q;
        if (bypass) begin
            id_inst = imem_rsp_data;
            id_pc   = pcq_head.pc;
        end else if (!fifo_empty) begin
            id_inst = fifo_head.inst;
            id_pc   = fifo_head.pc;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(imem_rsp_valid);
        drop_d        = drop_q;
        if (redirect_valid) begin
            pc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
            // Everything still owed after this cycle's response belongs to the old stream.
            drop_d = outstanding_q - OUT_W'(imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data ('{inst: imem_rsp_data, pc: pcq_head.pc}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Holds the PC of every kept request; dropped responses never had an entry.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (accept),
        .push_data ('{inst: NOP_INST, pc: pc_q}),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    logic unused_sink;
    assign unused_sink = ^{pcq_head.inst, pcq_count, pcq_full, pcq_empty, fifo_full,
                           redirect_pc[1:0]};

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int checks = 0;
    int errors = 0;

    // Memory model state: in-order queue of accepted addresses with due cycle.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          ready_mode = 0;

    // Logs of accepted request addresses and consumed decode bundles.
    logic [31:0] acc_q[$];
    logic [31:0] cons_pc_q[$];
    logic [31:0] cons_inst_q[$];

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: returns ~addr, mem_lat cycles after acceptance.
    always @(negedge clk) begin
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cyc + mem_lat);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        imem_req_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mem_addr_q[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_addr);
            if (id_valid && id_ready) begin
                cons_pc_q.push_back(id_pc);
                cons_inst_q.push_back(id_inst);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        cons_pc_q.delete();
        cons_inst_q.delete();
    endtask

    // Leaves the caller at the start of the first cycle after reset release.
    task automatic do_reset(input int lat, input int mode, input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = rdy;
        mem_lat        = lat;
        ready_mode     = mode;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid);
        end
        checks++;
        if (imem_addr !== 32'hBFC0_0000) begin
            errors++; $display("FAIL reset_addr got %h want bfc00000", imem_addr);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_id_valid got %b want 0", id_valid);
        end
        checks++;
        if (id_inst !== 32'h0) begin
            errors++; $display("FAIL reset_id_inst got %h want 00000000", id_inst);
        end
        checks++;
        if (id_pc !== 32'hBFC0_0000) begin
            errors++; $display("FAIL reset_id_pc got %h want bfc00000", id_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hBFC0_0000;
        exp_pc[1] = 32'hBFC0_0004;
        exp_pc[2] = 32'hBFC0_0008;
        do_reset(1, 0, 1'b1);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL stream_c0_req got %b/%h want 1/bfc00000", imem_req_valid, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hBFC0_0004 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_c1 got req %b addr %h idv %b want 1 bfc00004 0",
                     imem_req_valid, imem_addr, id_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0000 || id_inst !== 32'h403F_FFFF) begin
            errors++;
            $display("FAIL stream_first_id got %b %h %h want 1 bfc00000 403fffff",
                     id_valid, id_pc, id_inst);
        end
        repeat (10) next_cycle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_q.size() <= i || acc_q[i] !== exp_pc[i]) begin
                errors++;
                $display("FAIL stream_addr[%0d] got %h want %h", i,
                         (acc_q.size() > i) ? acc_q[i] : 32'hx, exp_pc[i]);
            end
            checks++;
            if (cons_pc_q.size() <= i || cons_pc_q[i] !== exp_pc[i]) begin
                errors++;
                $display("FAIL stream_id_pc[%0d] got %h want %h", i,
                         (cons_pc_q.size() > i) ? cons_pc_q[i] : 32'hx, exp_pc[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 0, 1'b0);
        repeat (12) begin
            @(negedge clk);
            if (id_valid) begin
                checks++;
                if (id_pc !== 32'hBFC0_0000 || id_inst !== 32'h403F_FFFF) begin
                    errors++;
                    $display("FAIL hold_head got %h/%h want bfc00000/403fffff", id_pc, id_inst);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (acc_q.size() != 2) begin
            errors++; $display("FAIL hold_req_count got %0d want 2", acc_q.size());
        end
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_flags got req %b idv %b want 0 1", imem_req_valid, id_valid);
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset(3, 0, 1'b1);
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1003;
        @(negedge clk);
        checks++;
        if (acc_q.size() != 2 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_pre got acc %0d req %b want 2 0", acc_q.size(), imem_req_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        repeat (15) next_cycle();
        checks++;
        if (acc_q.size() < 3 || acc_q[2] !== 32'h8000_1000) begin
            errors++;
            $display("FAIL redir_addr got %h want 80001000",
                     (acc_q.size() > 2) ? acc_q[2] : 32'hx);
        end
        checks++;
        if (cons_pc_q.size() < 2 || cons_pc_q[0] !== 32'h8000_1000 ||
            cons_inst_q[0] !== 32'h7FFF_EFFF || cons_pc_q[1] !== 32'h8000_1004) begin
            errors++;
            $display("FAIL redir_first_id got %h %h want 80001000 7fffefff then 80001004",
                     (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx,
                     (cons_inst_q.size() > 0) ? cons_inst_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_collision();
        do_reset(1, 0, 1'b1);
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        @(negedge clk);
        checks++;
        if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL coll_cycle got rsp %b idv %b want 1 0", imem_rsp_valid, id_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        repeat (10) next_cycle();
        checks++;
        if (cons_pc_q.size() < 1 || cons_pc_q[0] !== 32'h0000_1000 ||
            cons_inst_q[0] !== 32'hFFFF_EFFF) begin
            errors++;
            $display("FAIL coll_first_id got %h/%h want 00001000/ffffefff",
                     (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx,
                     (cons_inst_q.size() > 0) ? cons_inst_q[0] : 32'hx);
        end
        checks++;
        if (acc_q.size() < 3 || acc_q[2] !== 32'h0000_1000) begin
            errors++;
            $display("FAIL coll_addr got %h want 00001000",
                     (acc_q.size() > 2) ? acc_q[2] : 32'hx);
        end
    endtask

    task automatic test_ready_toggle();
        do_reset(3, 1, 1'b1);
        repeat (60) next_cycle();
        checks++;
        if (cons_pc_q.size() < 8) begin
            errors++; $display("FAIL toggle_count got %0d want >=8", cons_pc_q.size());
        end
        for (int i = 0; i < cons_pc_q.size(); i++) begin
            checks++;
            if (cons_pc_q[i] !== 32'hBFC0_0000 + 32'(4 * i) ||
                cons_inst_q[i] !== ~(32'hBFC0_0000 + 32'(4 * i))) begin
                errors++;
                $display("FAIL toggle_seq[%0d] got %h/%h want %h", i, cons_pc_q[i],
                         cons_inst_q[i], 32'hBFC0_0000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1, 0, 1'b1);
        repeat (6) next_cycle();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 ||
            id_pc !== 32'hBFC0_0000 || imem_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL midrst_outputs got req %b addr %h idv %b inst %h pc %h",
                     imem_req_valid, imem_addr, id_valid, id_inst, id_pc);
        end
        next_cycle();
        rst = 1'b0;
        clear_logs();
        repeat (10) next_cycle();
        checks++;
        if (acc_q.size() < 1 || acc_q[0] !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL midrst_addr got %h want bfc00000",
                     (acc_q.size() > 0) ? acc_q[0] : 32'hx);
        end
        checks++;
        if (cons_pc_q.size() < 1 || cons_pc_q[0] !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL midrst_id_pc got %h want bfc00000",
                     (cons_pc_q.size() > 0) ? cons_pc_q[0] : 32'hx);
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_collision();
        test_ready_toggle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
